// File: rtl/fp_mlt_arbiter_pkg.sv
// Shared types and helpers for the shared floating-point multiplier arbiter.
package fp_arb_pkg;

  localparam int DEF_LCYCLES = 2;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_EXP     = 8;
  localparam int DEF_MANT    = 7;

  // Widest configuration supported (NREQ up to 16), so tags fit every build.
  localparam int MAX_NREQ = 16;
  localparam int MAX_IDW  = 4;

  // One slot of the tag pipeline that rides alongside the multiplier.
  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
  } tag_t;

  // One-hot decode of a requester id; bits at or above nreq stay zero.
  function automatic logic [MAX_NREQ-1:0] onehot(input logic [MAX_IDW-1:0] id,
                                                 input int nreq);
    logic [MAX_NREQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (i < nreq && id == MAX_IDW'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/fp_mlt_arbiter_if.sv
// Requester-side bus of the multiplier arbiter.
//
// Handshake: a requester raises req_valid[i] with stable operands and keeps
// them until it sees req_ready[i]; the transfer happens in the cycle where
// req_valid[i] & req_ready[i] are both 1. Responses have no backpressure:
// rsp_valid[i] is a one-cycle strobe that the requester must take.
interface fp_mlt_arbiter_if
  import fp_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = 1 + DEF_EXP + DEF_MANT
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_dataa;
  logic [NREQ*WIDTH-1:0] req_datab;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;

  modport master (
    output req_valid, req_dataa, req_datab,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_dataa, req_datab,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fp_mlt_arbiter_rr_grant.sv
// Combinational round-robin grant: rotate by ptr, pick lowest, rotate back.
module rr_grant
  import fp_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gidx,
  output logic            any_gnt
);

  // Modulo-NREQ add; works for non-power-of-two requester counts.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                              input logic [IDW-1:0] b);
    logic [IDW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
    return sum[IDW-1:0];
  endfunction

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  pos;

  // Rotate the request vector so that index ptr lands on bit 0.
  always_comb begin
    rot = '0;
    for (int k = 0; k < NREQ; k++) rot[k] = req[wrap_add(ptr, IDW'(k))];
  end

  // Priority-encode the rotated vector: lowest set bit wins.
  always_comb begin
    pos     = '0;
    any_gnt = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos     = IDW'(k);
        any_gnt = 1'b1;
      end
    end
  end

  // Undo the rotation and form the one-hot grant.
  always_comb begin
    gidx = wrap_add(ptr, pos);
    gnt  = '0;
    for (int i = 0; i < NREQ; i++) gnt[i] = any_gnt && (gidx == IDW'(i));
  end

endmodule

// File: rtl/fp_mlt_arbiter.sv
// Shares one pipelined FP multiplier among NREQ requesters: round-robin
// grant, registered issue, tag pipeline matched to multiplier latency, and
// steering of each product back to its issuer.
module fp_mlt_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int EXP     = DEF_EXP,
  parameter int MANT    = DEF_MANT,
  parameter int WIDTH   = 1 + EXP + MANT,
  parameter int LCYCLES = DEF_LCYCLES,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                           clock,
  input  logic                           clock_areset_n,
  fp_mlt_arbiter_if.slave                bus,
  output logic                           mult_valid,
  output logic [WIDTH-1:0]               mult_dataa,
  output logic [WIDTH-1:0]               mult_datab,
  input  logic                           mult_result_valid,
  input  logic [WIDTH-1:0]               mult_result,
  output logic [$clog2(LCYCLES+3)-1:0]   inflight,
  output logic                           err_orphan
);

  localparam int INFW = $clog2(LCYCLES + 3);
  localparam int FLW  = $clog2(LCYCLES + 2);
  localparam logic [INFW-1:0] INF_MAX    = INFW'(LCYCLES + 2);
  localparam logic [FLW-1:0]  FLUSH_INIT = FLW'(LCYCLES + 1);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic            any_gnt;
  tag_t            tags [LCYCLES+1];
  tag_t            last;
  logic [FLW-1:0]  flush_cnt;
  logic            rsp_any;

  rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gidx    (gidx),
    .any_gnt (any_gnt)
  );

  // A grant is only ever raised on a valid request, so it is the handshake.
  assign bus.req_ready = gnt;
  assign last          = tags[LCYCLES];
  assign rsp_any       = |bus.rsp_valid;

  // Issue stage: advance the pointer and register the granted operands.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      ptr        <= '0;
      mult_valid <= 1'b0;
      mult_dataa <= '0;
      mult_datab <= '0;
    end else begin
      mult_valid <= any_gnt;
      if (any_gnt) begin
        ptr        <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        mult_dataa <= bus.req_dataa[int'(gidx)*WIDTH +: WIDTH];
        mult_datab <= bus.req_datab[int'(gidx)*WIDTH +: WIDTH];
      end
    end
  end

  // Tag pipeline: stage 0 loads with mult_valid, last stage meets the result.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      for (int k = 0; k <= LCYCLES; k++) tags[k] <= '0;
    end else begin
      tags[0] <= '{valid: any_gnt, id: MAX_IDW'(gidx)};
      for (int k = 1; k <= LCYCLES; k++) tags[k] <= tags[k-1];
    end
  end

  // Return stage: steer a tagged product to its issuer as a one-cycle strobe.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
    end else if (mult_result_valid && last.valid) begin
      bus.rsp_valid <= NREQ'(onehot(last.id, NREQ));
      bus.rsp_data  <= mult_result;
    end else begin
      bus.rsp_valid <= '0;
    end
  end

  // Orphan detection; untagged results right after reset are stale products
  // from before the reset and are dropped quietly while flush_cnt runs down.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      flush_cnt  <= FLUSH_INIT;
      err_orphan <= 1'b0;
    end else begin
      if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
      if (mult_result_valid && !last.valid && flush_cnt == '0) err_orphan <= 1'b1;
      if (!mult_result_valid && last.valid) err_orphan <= 1'b1;
    end
  end

  // Outstanding-operation count: up on handshake, down on response strobe.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      inflight <= '0;
    end else begin
      case ({any_gnt, rsp_any})
        2'b10:   if (inflight != INF_MAX) inflight <= inflight + 1'b1;
        2'b01:   if (inflight != '0) inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
